// File: rtl/mmio_button_port_pkg.sv
// Shared constants for the memory-mapped button port: register addresses,
// STATUS encoding modes and legacy button codes.
package bananachine_io_pkg;

  localparam logic [15:0] IO_STATUS_ADDR = 16'hFFFF;
  localparam logic [15:0] IO_EVENTS_ADDR = 16'hFFFE;

  localparam int unsigned MODE_LEGACY  = 0;
  localparam int unsigned MODE_BITMASK = 1;

  localparam int unsigned BTN_START = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_STATUS,
    REG_EVENTS
  } io_reg_e;

endpackage

// File: rtl/mmio_button_port_debouncer.sv
// One button channel: 2-FF synchroniser on the raw active-low pin, a
// consecutive-difference debounce counter, and a one-cycle press pulse.
module button_debouncer
  import bananachine_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic stable,
  output logic rise
);

  localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          pressed_sync;
  logic [CW-1:0] count;

  assign pressed_sync = ~sync[1];

  // count holds the number of differing cycles already seen, so the
  // DEBOUNCE_CYCLES-th differing cycle is the one that finds count == LAST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync   <= '1;
      stable <= 1'b0;
      count  <= '0;
      rise   <= 1'b0;
    end else begin
      sync <= {sync[0], button_n};
      rise <= 1'b0;
      if (pressed_sync == stable) begin
        count <= '0;
      end else if (count == LAST) begin
        stable <= pressed_sync;
        count  <= '0;
        rise   <= pressed_sync;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_button_port.sv
// Memory-mapped input port for active-low push buttons: STATUS (levels or
// legacy priority code) and sticky EVENTS (clear-on-read, write-1-to-clear).
module mmio_button_port
  import bananachine_io_pkg::*;
#(
  parameter int unsigned       WIDTH           = 16,
  parameter int unsigned       N_BUTTONS       = 3,
  parameter int unsigned       DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0]  BASE_ADDR       = WIDTH'(IO_STATUS_ADDR),
  parameter int unsigned       MODE            = MODE_LEGACY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] buttons_n,
  input  logic [WIDTH-1:0]     mem_address,
  input  logic                 loading,
  input  logic                 storing,
  input  logic [WIDTH-1:0]     data_to_mem_store,
  output logic                 io_hit,
  output logic [WIDTH-1:0]     io_read_data,
  output logic                 event_pending
);

  localparam logic [WIDTH-1:0] EVENTS_ADDR = BASE_ADDR - WIDTH'(1);

  logic [N_BUTTONS-1:0] stable;
  logic [N_BUTTONS-1:0] rise;
  logic [N_BUTTONS-1:0] events;
  logic [N_BUTTONS-1:0] clear_mask;
  logic [N_BUTTONS-1:0] events_next;
  logic [WIDTH-1:0]     status_value;
  logic [WIDTH-1:0]     read_value;
  logic                 read_req;
  io_reg_e              sel;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk     (clk),
      .reset   (reset),
      .button_n(buttons_n[i]),
      .stable  (stable[i]),
      .rise    (rise[i])
    );
  end

  if (N_BUTTONS < WIDTH) begin : g_store_pad
    logic unused_store_bits;
    assign unused_store_bits = ^data_to_mem_store[WIDTH-1:N_BUTTONS];
  end

  always_comb begin
    sel = REG_NONE;
    if (mem_address == BASE_ADDR) begin
      sel = REG_STATUS;
    end else if (mem_address == EVENTS_ADDR) begin
      sel = REG_EVENTS;
    end
  end

  assign read_req = loading && (sel != REG_NONE);

  // Descending scan so the lowest pressed channel (start) wins
  always_comb begin
    status_value = '0;
    if (MODE == MODE_BITMASK) begin
      status_value = WIDTH'(stable);
    end else begin
      for (int unsigned i = N_BUTTONS; i > 0; i--) begin
        if (stable[i-1]) status_value = WIDTH'(i);
      end
    end
  end

  assign read_value = (sel == REG_STATUS) ? status_value : WIDTH'(events);

  // A load wins over a simultaneous store; new presses win over any clear
  always_comb begin
    clear_mask = '0;
    if (sel == REG_EVENTS) begin
      if (loading) begin
        clear_mask = events;
      end else if (storing) begin
        clear_mask = data_to_mem_store[N_BUTTONS-1:0];
      end
    end
    events_next = (events & ~clear_mask) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      events        <= '0;
      event_pending <= 1'b0;
      io_hit        <= 1'b0;
      io_read_data  <= '0;
    end else begin
      events        <= events_next;
      event_pending <= |events_next;
      io_hit        <= read_req;
      io_read_data  <= read_req ? read_value : '0;
    end
  end

endmodule

// File: tb/tb_mmio_button_port.sv
// Bench for mmio_button_port: directed scenarios plus random buttons and bus
// traffic, both STATUS modes compared against a window-based reference model.
module tb_mmio_button_port;
  import bananachine_io_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned N = 3;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] buttons_n = '1;
  logic [W-1:0] mem_address = '0;
  logic         loading = 1'b0;
  logic         storing = 1'b0;
  logic [W-1:0] data_to_mem_store = '0;

  logic         hit_l, hit_m, pend_l, pend_m;
  logic [W-1:0] rd_l, rd_m;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mmio_button_port #(
    .WIDTH(W), .N_BUTTONS(N), .DEBOUNCE_CYCLES(D),
    .BASE_ADDR(IO_STATUS_ADDR), .MODE(MODE_LEGACY)
  ) u_legacy (
    .clk(clk), .reset(reset), .buttons_n(buttons_n),
    .mem_address(mem_address), .loading(loading), .storing(storing),
    .data_to_mem_store(data_to_mem_store),
    .io_hit(hit_l), .io_read_data(rd_l), .event_pending(pend_l)
  );

  mmio_button_port #(
    .WIDTH(W), .N_BUTTONS(N), .DEBOUNCE_CYCLES(D),
    .BASE_ADDR(IO_STATUS_ADDR), .MODE(MODE_BITMASK)
  ) u_mask (
    .clk(clk), .reset(reset), .buttons_n(buttons_n),
    .mem_address(mem_address), .loading(loading), .storing(storing),
    .data_to_mem_store(data_to_mem_store),
    .io_hit(hit_m), .io_read_data(rd_m), .event_pending(pend_m)
  );

  // Reference model: a level is accepted once the last D synchronised samples
  // all disagree with the current accepted level.
  logic [N-1:0] m_pipe1, m_pipe2, m_stable, m_events, m_rise;
  logic [N-1:0] m_window[$];
  logic         m_hit, m_pend;
  logic [W-1:0] m_rd_l, m_rd_m;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [W-1:0] legacy_code(input logic [N-1:0] s);
    if (s[0]) return W'(BTN_START);
    if (s[1]) return W'(BTN_LEFT);
    if (s[2]) return W'(BTN_RIGHT);
    return '0;
  endfunction

  task automatic model_reset();
    m_pipe1 = '0; m_pipe2 = '0; m_stable = '0; m_events = '0; m_rise = '0;
    m_window.delete();
    m_hit = 1'b0; m_pend = 1'b0; m_rd_l = '0; m_rd_m = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] next_stable, clr, ev_next;
    logic         is_status, is_events, rd;
    bit           all_diff;
    m_window.push_back(m_pipe2);
    if (m_window.size() > D) void'(m_window.pop_front());
    next_stable = m_stable;
    if (m_window.size() == D) begin
      for (int unsigned b = 0; b < N; b++) begin
        all_diff = 1'b1;
        for (int unsigned k = 0; k < D; k++)
          if (m_window[k][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) next_stable[b] = ~m_stable[b];
      end
    end
    is_status = (mem_address == IO_STATUS_ADDR);
    is_events = (mem_address == IO_EVENTS_ADDR);
    rd = loading && (is_status || is_events);
    m_hit  = rd;
    m_rd_l = !rd ? '0 : (is_status ? legacy_code(m_stable) : W'(m_events));
    m_rd_m = !rd ? '0 : (is_status ? W'(m_stable) : W'(m_events));
    clr = '0;
    if (rd && is_events) clr = m_events;
    else if (storing && !loading && is_events) clr = data_to_mem_store[N-1:0];
    ev_next  = (m_events & ~clr) | m_rise;
    m_rise   = next_stable & ~m_stable;
    m_events = ev_next;
    m_pend   = |ev_next;
    m_stable = next_stable;
    m_pipe2  = m_pipe1;
    m_pipe1  = ~buttons_n;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("legacy.io_hit", W'(hit_l), W'(m_hit));
    check("legacy.io_read_data", rd_l, m_rd_l);
    check("legacy.event_pending", W'(pend_l), W'(m_pend));
    check("mask.io_hit", W'(hit_m), W'(m_hit));
    check("mask.io_read_data", rd_m, m_rd_m);
    check("mask.event_pending", W'(pend_m), W'(m_pend));
  endtask

  task automatic bus(input logic ld, input logic st, input logic [W-1:0] addr,
                     input logic [W-1:0] data);
    loading = ld; storing = st; mem_address = addr; data_to_mem_store = data;
  endtask

  task automatic idle_ticks(input int n);
    bus(1'b0, 1'b0, '0, '0);
    repeat (n) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".legacy.io_hit"}, W'(hit_l), '0);
    check({tag, ".legacy.io_read_data"}, rd_l, '0);
    check({tag, ".legacy.event_pending"}, W'(pend_l), '0);
    check({tag, ".mask.io_hit"}, W'(hit_m), '0);
    check({tag, ".mask.io_read_data"}, rd_m, '0);
    check({tag, ".mask.event_pending"}, W'(pend_m), '0);
  endtask

  task automatic reset_pulse();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("reset_pulse");
    buttons_n = '1;
    bus(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int idx;
    model_reset();
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 1: idle read of STATUS
    bus(1'b1, 1'b0, IO_STATUS_ADDR, '0); tick();
    check("s1.hit", W'(hit_l), W'(1));
    check("s1.status", rd_l, '0);

    // 2: 3-cycle glitch on left
    buttons_n[1] = 1'b0; idle_ticks(3);
    buttons_n[1] = 1'b1; idle_ticks(8);
    bus(1'b1, 1'b0, IO_STATUS_ADDR, '0); tick();
    check("s2.legacy_status", rd_l, '0);
    check("s2.mask_status", rd_m, '0);
    bus(1'b1, 1'b0, IO_EVENTS_ADDR, '0); tick();
    check("s2.events", rd_l, '0);

    // 3: held left press
    buttons_n[1] = 1'b0; idle_ticks(10);
    bus(1'b1, 1'b0, IO_STATUS_ADDR, '0); tick();
    check("s3.legacy_status", rd_l, W'(BTN_LEFT));
    check("s3.mask_status", rd_m, 16'h0002);
    buttons_n = '1; idle_ticks(10);
    bus(1'b1, 1'b0, IO_EVENTS_ADDR, '0); tick();
    idle_ticks(1);

    // 4: start+right, then release start
    buttons_n = 3'b010; idle_ticks(10);
    bus(1'b1, 1'b0, IO_STATUS_ADDR, '0); tick();
    check("s4.legacy_both", rd_l, W'(BTN_START));
    check("s4.mask_both", rd_m, 16'h0005);
    buttons_n = 3'b011; idle_ticks(5);
    bus(1'b1, 1'b0, IO_STATUS_ADDR, '0); tick();
    check("s4.legacy_before", rd_l, W'(BTN_START));
    tick();
    check("s4.legacy_after", rd_l, W'(BTN_RIGHT));
    buttons_n = '1; idle_ticks(10);
    bus(1'b1, 1'b0, IO_EVENTS_ADDR, '0); tick();
    idle_ticks(1);

    // 5: right press, clear-on-read, then write-1-to-clear
    buttons_n = 3'b011; idle_ticks(10);
    check("s5.pending", W'(pend_l), W'(1));
    bus(1'b1, 1'b0, IO_EVENTS_ADDR, '0); tick();
    check("s5.events", rd_l, 16'h0004);
    idle_ticks(1);
    check("s5.pending_cleared", W'(pend_l), '0);
    bus(1'b1, 1'b0, IO_EVENTS_ADDR, '0); tick();
    check("s5.events_cleared", rd_l, '0);
    buttons_n = '1; idle_ticks(10);
    buttons_n = 3'b011; idle_ticks(10);
    bus(1'b0, 1'b1, IO_EVENTS_ADDR, 16'h0004); tick();
    bus(1'b1, 1'b0, IO_EVENTS_ADDR, '0); tick();
    check("s5.w1c", rd_l, '0);

    // 6: start press lands on the same edge as an EVENTS read
    buttons_n = '1; idle_ticks(10);
    buttons_n = 3'b101; idle_ticks(10);
    buttons_n = 3'b100; idle_ticks(6);
    bus(1'b1, 1'b0, IO_EVENTS_ADDR, '0); tick();
    check("s6.old_value", rd_l, 16'h0002);
    tick();
    check("s6.set_wins", rd_l, 16'h0001);

    // 7: reset mid-debounce with events pending
    buttons_n = '1; idle_ticks(10);
    buttons_n = 3'b011; idle_ticks(10);
    check("s7.pending_before", W'(pend_m), W'(1));
    buttons_n = 3'b101; idle_ticks(3);
    reset_pulse();
    idle_ticks(12);
    check("s7.no_event", W'(pend_l), '0);
    bus(1'b1, 1'b0, IO_EVENTS_ADDR, '0); tick();
    check("s7.events", rd_m, '0);
    bus(1'b1, 1'b0, IO_STATUS_ADDR, '0); tick();
    check("s7.status", rd_l, '0);

    // random buttons and bus traffic
    for (int unsigned it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, N - 1));
        buttons_n[idx] = ~buttons_n[idx];
      end
      case ($urandom_range(0, 9))
        0, 1, 2: bus(1'b1, 1'b0, IO_STATUS_ADDR, W'($urandom));
        3, 4, 5: bus(1'b1, 1'b0, IO_EVENTS_ADDR, W'($urandom));
        6:       bus(1'b0, 1'b1, IO_EVENTS_ADDR, W'($urandom));
        7:       bus(1'b0, 1'b1, IO_STATUS_ADDR, W'($urandom));
        8:       bus(1'b1, 1'b1, IO_EVENTS_ADDR, W'($urandom));
        default: bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     W'($urandom), W'($urandom));
      endcase
      if (it == 1500) reset_pulse();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
